// File: rtl/core_global_regs.sv
// Global register block for the radio core: settings registers, registered
// readback mux, PLL-lock loss monitoring and PPS period/presence monitoring.
module core_global_regs #(
    parameter logic [31:0] SR_BASE     = 32'd0,
    parameter int unsigned NUM_LOCKS   = 2,
    parameter int unsigned LOSS_CNT_W  = 8,
    parameter int unsigned PPS_TIMEOUT = 200000000,
    parameter logic [31:0] COMPAT      = 32'hAB000B00,
    parameter logic [31:0] GIT_HASH    = 32'h0
) (
    input  logic                 bus_clk,
    input  logic                 bus_rst,
    input  logic                 set_stb,
    input  logic [31:0]          set_addr,
    input  logic [31:0]          set_data,
    output logic [31:0]          rb_data,
    input  logic [NUM_LOCKS-1:0] lock_signals,
    input  logic [3:0]           tcxo_status,
    input  logic                 pps,
    output logic [1:0]           pps_select,
    output logic                 mimo,
    output logic                 codec_arst,
    output logic [31:0]          misc_out,
    output logic [7:0]           xb_local_addr,
    output logic                 lock_lost
);
    localparam logic [31:0] ADDR_RB   = SR_BASE;
    localparam logic [31:0] ADDR_MISC = SR_BASE + 32'd4;
    localparam logic [31:0] ADDR_TEST = SR_BASE + 32'd28;
    localparam logic [31:0] ADDR_XB   = SR_BASE + 32'd32;
    localparam logic [31:0] ADDR_CLR  = SR_BASE + 32'd36;
    localparam logic [31:0] TIMEOUT_LAST = 32'(PPS_TIMEOUT - 1);
    localparam logic [LOSS_CNT_W-1:0] CNT_MAX = '1;

    logic [4:0]            rb_addr;
    logic [31:0]           test_reg;
    logic [NUM_LOCKS-1:0]  sync1, sync2, sticky, loss;
    logic [LOSS_CNT_W-1:0] loss_cnt [NUM_LOCKS];
    logic                  pps_d, pps_rise, pps_present;
    logic [31:0]           pps_timer, pps_period;
    logic [31:0]           rb_next;
    logic                  wr_rb, wr_misc, wr_test, wr_xb, wr_clr;

    assign wr_rb   = set_stb && (set_addr == ADDR_RB);
    assign wr_misc = set_stb && (set_addr == ADDR_MISC);
    assign wr_test = set_stb && (set_addr == ADDR_TEST);
    assign wr_xb   = set_stb && (set_addr == ADDR_XB);
    assign wr_clr  = set_stb && (set_addr == ADDR_CLR);

    // Settings registers
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            rb_addr       <= '0;
            misc_out      <= 32'h2;
            test_reg      <= '0;
            xb_local_addr <= 8'd40;
        end else begin
            if (wr_rb)   rb_addr       <= set_data[4:0];
            if (wr_misc) misc_out      <= set_data;
            if (wr_test) test_reg      <= set_data;
            if (wr_xb)   xb_local_addr <= set_data[7:0];
        end
    end

    assign pps_select = misc_out[1:0];
    assign mimo       = misc_out[2];
    assign codec_arst = misc_out[3];

    // A falling synchronised lock is a loss; it beats a same-edge clear.
    assign loss = sync2 & ~sync1;

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            sync1  <= '0;
            sync2  <= '0;
            sticky <= '0;
            for (int i = 0; i < int'(NUM_LOCKS); i++) loss_cnt[i] <= '0;
        end else begin
            sync1 <= lock_signals;
            sync2 <= sync1;
            for (int i = 0; i < int'(NUM_LOCKS); i++) begin
                if (loss[i]) begin
                    sticky[i] <= 1'b1;
                    if (wr_clr && set_data[i])
                        loss_cnt[i] <= LOSS_CNT_W'(1);
                    else if (loss_cnt[i] != CNT_MAX)
                        loss_cnt[i] <= loss_cnt[i] + LOSS_CNT_W'(1);
                end else if (wr_clr && set_data[i]) begin
                    sticky[i]   <= 1'b0;
                    loss_cnt[i] <= '0;
                end
            end
        end
    end

    assign lock_lost = |sticky;

    // PPS period meter; the timer saturates so a dead PPS never aliases
    assign pps_rise = pps & ~pps_d;

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            pps_d       <= 1'b0;
            pps_timer   <= '0;
            pps_period  <= '0;
            pps_present <= 1'b0;
        end else begin
            pps_d <= pps;
            if (pps_rise) begin
                pps_period  <= pps_timer + 32'd1;
                pps_timer   <= '0;
                pps_present <= 1'b1;
            end else begin
                if (pps_timer != 32'hFFFF_FFFF) pps_timer <= pps_timer + 32'd1;
                if (pps_timer == TIMEOUT_LAST) pps_present <= 1'b0;
            end
        end
    end

    always_comb begin
        rb_next = 32'hDEADBEEF;
        case (rb_addr)
            5'd1:    rb_next = {25'd0, pps_present, tcxo_status, misc_out[1:0]};
            5'd2:    rb_next = COMPAT;
            5'd3:    rb_next = GIT_HASH;
            5'd4:    rb_next = 32'(sync2);
            5'd5:    rb_next = 32'(sticky);
            5'd6:    rb_next = pps_period;
            5'd24:   rb_next = test_reg;
            default: ;
        endcase
        for (int i = 0; i < int'(NUM_LOCKS); i++)
            if (rb_addr == 5'(8 + i)) rb_next = 32'(loss_cnt[i]);
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) rb_data <= '0;
        else         rb_data <= rb_next;
    end

endmodule
